spike_rate_encoder: RTL and testbench
=====================================

# spike_rate_encoder

Converts a multi-bit intensity value into a deterministic binary spike train over a fixed window of timesteps, for driving the single-bit input of a binary LIF neuron. It sits between the feature/pixel source and the neuron array. It accepts one value per window through a valid/ready handshake. It then emits one spike bit per timestep strobe using a carry-out phase accumulator, so the spike count is an exact function of the value.

## Interface
- W, 8: width of the input value and of the phase accumulator. Value is unsigned; rate = value / 2^W.
- WINDOW, 256: timesteps per encoded value. Must be ≥ 1 and < 2^16.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_value is offered.
- in_ready  output  1  encoder is idle and can accept a value.
- in_value  input  W  unsigned intensity.
- step_en  input  1  timestep strobe; one spike bit is produced per strobe while running.
- clear  input  1  synchronous abort; returns to IDLE.
- spike  output  1  encoded spike bit S(t); feeds the neuron's binary input.
- spike_valid  output  1  spike is valid for this timestep; one-cycle pulse per consumed strobe.
- busy  output  1  window in progress.
- done  output  1  one-cycle pulse with the last spike_valid of a window.

## Operation
- Internal registers:
  - state: IDLE or RUN.
  - value_q: W bits.
  - acc: W bits.
  - step_cnt: ceil(log2(WINDOW+1)) bits.
- Reset (async, rst_n=0):
  - state=IDLE.
  - acc=0, value_q=0, step_cnt=0.
  - spike=0, spike_valid=0, done=0.
  - Outputs in_ready=1, busy=0 while in reset.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid && in_ready: value_q<=in_value, acc<=0, step_cnt<=0, go RUN.
  - step_en in IDLE is ignored; spike_valid stays 0.
- RUN:
  - in_ready=0, busy=1; in_valid is ignored.
  - On each cycle with step_en=1, compute the (W+1)-bit sum = acc + value_q.
  - Updates: acc<=sum[W-1:0], spike<=sum[W], spike_valid<=1, step_cnt<=step_cnt+1.
  - If step_cnt==WINDOW-1 on that strobe: done<=1 and state<=IDLE at the same edge.
  - Cycles without step_en: spike_valid<=0, done<=0, acc and step_cnt held. The spike register value is don't-care but is driven to 0.
- Spike count per window is exactly floor(value × WINDOW / 2^W).
  - Spikes are evenly spaced; the first spike occurs at step index ceil(2^W/value)−1 (0-based).
  - value=0 gives no spikes.
- clear=1 in any state:
  - Next edge: state=IDLE, acc=0, step_cnt=0, spike_valid=0, done=0, spike=0.
  - No done pulse is generated.
  - clear has priority over both the handshake and step_en.
- Arithmetic is unsigned, with no saturation. The carry out of bit W-1 is the spike; the wrap of acc is intended.

## Timing
- Handshake: a transfer occurs on the rising edge where in_valid && in_ready. in_ready is a combinational decode of state (IDLE).
- A step_en coincident with the accepting edge is not consumed. The first consumable strobe is in the cycle after acceptance.
- Spike latency: spike/spike_valid are registered and appear in the cycle after step_en was sampled high.
- Last step:
  - done and the final spike_valid assert in the same cycle.
  - in_ready is already 1 in that cycle, so a new value can be accepted in that cycle (back-to-back windows, zero bubble).
- Minimum window duration: WINDOW strobes. With step_en held high, the window takes WINDOW cycles after acceptance.
- Reset mid-window: the window is discarded immediately (async); the value is not retained.

## Test plan
- Reset: assert rst_n=0 mid-RUN with W=8, WINDOW=256, value=64 → spike, spike_valid and done drop to 0 asynchronously; after release in_ready=1, busy=0.
- W=8, WINDOW=256, value=64, step_en held high → exactly 64 spikes, at step indices 3,7,…,255; done pulses with step 255; in_ready=1 the same cycle.
- value=0 → 256 spike_valid pulses, 0 spikes, single done pulse. value=255 → 255 spikes, with only step 0 silent.
- WINDOW=10, value=128, step_en toggling every third cycle → spikes at steps 1,3,5,7,9 (5 total); acc and step_cnt hold between strobes; spike_valid pulses exactly 10 times.
- Back-to-back: present value=128 then value=32 with in_valid held through done → second window starts with acc=0 with no idle cycle; spike counts are 128 and 32 (WINDOW=256).
- clear asserted at step 100 of a value=200 window → IDLE next cycle, no done pulse; a newly accepted value=200 still yields 156 spikes (WINDOW=200: floor(200×200/256)).

Source files
------------

// File: rtl/spike_rate_encoder.sv
// Rate encoder: turns one unsigned intensity per window into WINDOW spike bits
// using the carry-out of a phase accumulator, so the spike count is exact.
module spike_rate_encoder #(
    parameter int W      = 8,
    parameter int WINDOW = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_value,
    input  logic         step_en,
    input  logic         clear,
    output logic         spike,
    output logic         spike_valid,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(WINDOW + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [W-1:0]  r_value;
    logic [W-1:0]  w_value_next;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  w_acc_next;
    logic [CW-1:0] r_step_cnt;
    logic [CW-1:0] w_step_cnt_next;
    logic          r_spike;
    logic          w_spike_next;
    logic          r_spike_valid;
    logic          w_spike_valid_next;
    logic          r_done;
    logic          w_done_next;

    logic [W:0]    w_sum;
    logic          w_last_step;

    // The carry out of the W-bit add is the spike; the wrap of acc is intended.
    assign w_sum       = {1'b0, r_acc} + {1'b0, r_value};
    assign w_last_step = (r_step_cnt == CW'(WINDOW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_value       <= '0;
            r_acc         <= '0;
            r_step_cnt    <= '0;
            r_spike       <= 1'b0;
            r_spike_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_value       <= w_value_next;
            r_acc         <= w_acc_next;
            r_step_cnt    <= w_step_cnt_next;
            r_spike       <= w_spike_next;
            r_spike_valid <= w_spike_valid_next;
            r_done        <= w_done_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_value_next       = r_value;
        w_acc_next         = r_acc;
        w_step_cnt_next    = r_step_cnt;
        w_spike_next       = 1'b0;
        w_spike_valid_next = 1'b0;
        w_done_next        = 1'b0;

        if (clear) begin
            // Abort wins over both the handshake and any pending strobe.
            w_state_next    = S_IDLE;
            w_acc_next      = '0;
            w_step_cnt_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        w_value_next    = in_value;
                        w_acc_next      = '0;
                        w_step_cnt_next = '0;
                        w_state_next    = S_RUN;
                    end
                end
                S_RUN: begin
                    if (step_en) begin
                        w_acc_next         = w_sum[W-1:0];
                        w_spike_next       = w_sum[W];
                        w_spike_valid_next = 1'b1;
                        w_step_cnt_next    = r_step_cnt + CW'(1);
                        // Returning to IDLE on the last strobe lets the next value
                        // be accepted in the same cycle that done is visible.
                        if (w_last_step) begin
                            w_done_next  = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state == S_RUN);
    assign spike       = r_spike;
    assign spike_valid = r_spike_valid;
    assign done        = r_done;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed plus randomized checks of spike_rate_encoder against an arithmetic
// reference: spike at step k iff floor((k+1)v/256) > floor(kv/256).
module tb_spike_rate_encoder;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      in_valid;
    logic [2:0]      in_ready;
    logic [2:0][7:0] in_value;
    logic [2:0]      step_en;
    logic [2:0]      clear;
    logic [2:0]      spike;
    logic [2:0]      spike_valid;
    logic [2:0]      busy;
    logic [2:0]      done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spike_rate_encoder #(.W(8), .WINDOW(256)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_value(in_value[0]), .step_en(step_en[0]), .clear(clear[0]),
        .spike(spike[0]), .spike_valid(spike_valid[0]), .busy(busy[0]), .done(done[0])
    );

    spike_rate_encoder #(.W(8), .WINDOW(10)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_value(in_value[1]), .step_en(step_en[1]), .clear(clear[1]),
        .spike(spike[1]), .spike_valid(spike_valid[1]), .busy(busy[1]), .done(done[1])
    );

    spike_rate_encoder #(.W(8), .WINDOW(200)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_value(in_value[2]), .step_en(step_en[2]), .clear(clear[2]),
        .spike(spike[2]), .spike_valid(spike_valid[2]), .busy(busy[2]), .done(done[2])
    );

    function automatic logic exp_spike(input int v, input int k);
        return (((k + 1) * v) / 256) != ((k * v) / 256);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer a value while idle; a coincident strobe must not be consumed.
    task automatic accept(input int idx, input int v);
        in_valid[idx] = 1'b1;
        in_value[idx] = 8'(v);
        step_en[idx]  = 1'b1;
        check("ready_before_accept", 32'(in_ready[idx]), 1);
        @(negedge clk);
        in_valid[idx] = 1'b0;
        step_en[idx]  = 1'b0;
        check("busy_after_accept", 32'(busy[idx]), 1);
        check("ready_after_accept", 32'(in_ready[idx]), 0);
        check("no_sv_on_accept", 32'(spike_valid[idx]), 0);
    endtask

    // Issue n strobes (steps k0..k0+n-1), each preceded by period-1 idle cycles.
    task automatic strobes(input int idx, input int v, input int win, input int period,
                           input int k0, input int n, output int nsp);
        nsp = 0;
        for (int k = k0; k < k0 + n; k++) begin
            for (int p = 1; p < period; p++) begin
                step_en[idx] = 1'b0;
                @(negedge clk);
                check("gap_sv", 32'(spike_valid[idx]), 0);
                check("gap_done", 32'(done[idx]), 0);
            end
            step_en[idx] = 1'b1;
            @(negedge clk);
            check("sv", 32'(spike_valid[idx]), 1);
            check("spike", 32'(spike[idx]), 32'(exp_spike(v, k)));
            check("done", 32'(done[idx]), 32'(k == win - 1));
            if (k == win - 1) check("ready_at_done", 32'(in_ready[idx]), 1);
            else              check("busy_in_run", 32'(busy[idx]), 1);
            if (spike[idx]) nsp++;
        end
        step_en[idx] = 1'b0;
    endtask

    task automatic full_window(input int idx, input int v, input int win, input int period);
        int nsp;
        accept(idx, v);
        strobes(idx, v, win, period, 0, win, nsp);
        check("spike_count", 32'(nsp), 32'((v * win) / 256));
        $display("window dut%0d value=%0d window=%0d period=%0d spikes=%0d", idx, v, win, period, nsp);
    endtask

    initial begin
        int nsp;
        int v;
        int per;
        rst_n    = 1'b0;
        in_valid = '0;
        in_value = '0;
        step_en  = '0;
        clear    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", 32'(in_ready[i]), 1);
            check("rst_busy", 32'(busy[i]), 0);
            check("rst_sv", 32'(spike_valid[i]), 0);
        end

        // Strobes while idle are ignored.
        step_en[0] = 1'b1;
        @(negedge clk);
        check("idle_step_sv", 32'(spike_valid[0]), 0);
        step_en[0] = 1'b0;

        // Async reset mid-window right after a spike at step 3.
        accept(0, 64);
        strobes(0, 64, 256, 1, 0, 4, nsp);
        check("pre_reset_spike", 32'(spike[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_spike", 32'(spike[0]), 0);
        check("async_rst_sv", 32'(spike_valid[0]), 0);
        check("async_rst_done", 32'(done[0]), 0);
        check("async_rst_ready", 32'(in_ready[0]), 1);
        check("async_rst_busy", 32'(busy[0]), 0);
        $display("reset mid-window dut0 value=64");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready[0]), 1);
        check("post_rst_busy", 32'(busy[0]), 0);

        full_window(0, 64, 256, 1);
        full_window(0, 0, 256, 1);
        full_window(0, 255, 256, 1);
        full_window(1, 128, 10, 3);

        // Back-to-back: next value offered during RUN (ignored) and through done.
        accept(0, 128);
        in_valid[0] = 1'b1;
        in_value[0] = 8'd32;
        strobes(0, 128, 256, 1, 0, 256, nsp);
        check("b2b_count1", 32'(nsp), 128);
        accept(0, 32);
        strobes(0, 32, 256, 1, 0, 256, nsp);
        check("b2b_count2", 32'(nsp), 32);
        $display("back-to-back dut0 values=128,32 second_spikes=%0d", nsp);

        // Clear at step 100 wins over strobe and handshake; no done pulse.
        accept(2, 200);
        strobes(2, 200, 200, 1, 0, 100, nsp);
        clear[2]    = 1'b1;
        step_en[2]  = 1'b1;
        in_valid[2] = 1'b1;
        in_value[2] = 8'd200;
        @(negedge clk);
        clear[2]    = 1'b0;
        step_en[2]  = 1'b0;
        in_valid[2] = 1'b0;
        check("clear_sv", 32'(spike_valid[2]), 0);
        check("clear_done", 32'(done[2]), 0);
        check("clear_spike", 32'(spike[2]), 0);
        check("clear_busy", 32'(busy[2]), 0);
        check("clear_ready", 32'(in_ready[2]), 1);
        $display("clear dut2 at step 100");
        full_window(2, 200, 200, 1);

        for (int r = 0; r < 4; r++) begin
            v   = int'($urandom_range(0, 255));
            per = int'($urandom_range(1, 3));
            full_window(1, v, 10, per);
        end
        for (int r = 0; r < 2; r++) begin
            v   = int'($urandom_range(0, 255));
            per = int'($urandom_range(1, 2));
            full_window(0, v, 256, per);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
